// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller state
// encoding and the default operand width.
package serial_arith_pkg;

    // Operand width used when a block is instantiated without an override.
    localparam int SA_DEFAULT_WIDTH = 8;

    // Controller states; 2-bit encoding leaves 2'd3 unused (recovers to IDLE).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the serial adder.
// The slave side is the adder itself, the master side is its user.
interface serial_adder_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        input  cin,
        output out_valid,
        input  out_ready,
        output sum,
        output cout,
        output ovf
    );

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        output cin,
        input  out_valid,
        output out_ready,
        input  sum,
        input  cout,
        input  ovf
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder; the bit cell of the serial adder and the sibling of
// the full_subtractor cell. Purely combinational.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder. Operands are captured on an input
// handshake, added LSB-first one bit per clock through a single full-adder
// cell and a carry flop, and the result (sum, carry-out, signed overflow) is
// held behind an output handshake until consumed.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    // Controller state
    sa_state_e        r_state;
    sa_state_e        w_next_state;

    // Datapath registers
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    // Result registers, only written on entry to DONE
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Bit cell and control decodes
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_accept;
    logic             w_busy;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_busy   = (r_state == BUSY);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // The single bit cell: current LSBs of both operands plus the running carry.
    full_adder u_bit_cell (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH bit steps in BUSY, wait for the consumer in DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = BUSY;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = BUSY;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and carry/counter update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= {WIDTH{1'b0}};
            r_b_sh   <= {WIDTH{1'b0}};
            r_sum_sh <= {WIDTH{1'b0}};
            r_carry  <= 1'b0;
            r_cnt    <= {CW{1'b0}};
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_sum_sh <= {WIDTH{1'b0}};
            r_carry  <= bus.cin;
            r_cnt    <= {CW{1'b0}};
        end else if (w_busy) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_sum_sh <= {w_fa_sum, r_sum_sh[WIDTH-1:1]};
            r_carry  <= w_fa_cout;
            r_cnt    <= r_cnt + CW'(1);
        end else begin
            r_a_sh   <= r_a_sh;
            r_b_sh   <= r_b_sh;
            r_sum_sh <= r_sum_sh;
            r_carry  <= r_carry;
            r_cnt    <= r_cnt;
        end
    end

    // Result capture on the last bit step; the carry flop still holds the
    // carry into the MSB there, so overflow is that XOR the cell's carry-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_busy && w_last) begin
            r_sum  <= {w_fa_sum, r_sum_sh[WIDTH-1:1]};
            r_cout <= w_fa_cout;
            r_ovf  <= r_carry ^ w_fa_cout;
        end else begin
            r_sum  <= r_sum;
            r_cout <= r_cout;
            r_ovf  <= r_ovf;
        end
    end

    // Handshake flags are plain decodes of the state register.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule
